// File: rtl/victim_cache_assoc.sv
// Fully-associative victim cache: combinational lookup, synchronous insert /
// invalidate / flush, FIFO or true-LRU replacement, registered eviction report.
module victim_cache_assoc #(
    parameter int unsigned TAG_WIDTH   = 20,
    parameter int unsigned INDEX_WIDTH = 6,
    parameter int unsigned LINE_WIDTH  = 512,
    parameter int unsigned CAPACITY    = 16,
    parameter int unsigned REPL_MODE   = 0,
    localparam int unsigned KEY_W      = TAG_WIDTH + INDEX_WIDTH,
    localparam int unsigned WAY_W      = $clog2(CAPACITY)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rd_en,
    input  logic [KEY_W-1:0]      r_key,
    output logic                  victim_hit,
    output logic [WAY_W-1:0]      hit_way,
    output logic [LINE_WIDTH-1:0] data_out,
    input  logic                  we,
    input  logic [KEY_W-1:0]      w_key,
    input  logic [LINE_WIDTH-1:0] data_in,
    input  logic                  inv_en,
    input  logic [KEY_W-1:0]      inv_key,
    input  logic                  flush,
    output logic                  evict_valid,
    output logic [KEY_W-1:0]      evict_key,
    output logic [LINE_WIDTH-1:0] evict_data,
    output logic [WAY_W:0]        occupancy
);

    logic [CAPACITY-1:0]   r_valid;
    logic [KEY_W-1:0]      r_keys  [CAPACITY];
    logic [LINE_WIDTH-1:0] r_lines [CAPACITY];
    logic [WAY_W-1:0]      r_age   [CAPACITY];
    logic [WAY_W-1:0]      r_ptr;
    logic                  r_evict_valid;
    logic [KEY_W-1:0]      r_evict_key;
    logic [LINE_WIDTH-1:0] r_evict_data;
    logic [WAY_W:0]        r_occ;

    logic [CAPACITY-1:0] w_match, w_wmatch, w_imatch, w_valid_d;
    logic                w_hit, w_dup, w_has_free, w_evict, w_do_ins, w_touch_en;
    logic [WAY_W-1:0]    w_hit_way, w_dup_way, w_free_way, w_lru_way, w_victim_way;
    logic [WAY_W-1:0]    w_ins_way, w_touch_way;
    logic [WAY_W:0]      w_occ_d;

    // Key compare of every entry against the lookup, insert and invalidate keys.
    always_comb begin
        for (int i = 0; i < CAPACITY; i++) begin
            w_match[i]  = r_valid[i] && (r_keys[i] == r_key);
            w_wmatch[i] = r_valid[i] && (r_keys[i] == w_key);
            w_imatch[i] = r_valid[i] && (r_keys[i] == inv_key);
        end
    end

    // Lowest-index priority encoders for hit, duplicate, free slot; LRU oldest entry.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_dup      = 1'b0;
        w_dup_way  = '0;
        w_has_free = 1'b0;
        w_free_way = '0;
        w_lru_way  = '0;
        for (int i = CAPACITY - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(i);
            end
            if (w_wmatch[i]) begin
                w_dup     = 1'b1;
                w_dup_way = WAY_W'(i);
            end
            if (!r_valid[i]) begin
                w_has_free = 1'b1;
                w_free_way = WAY_W'(i);
            end
            if (r_age[i] == WAY_W'(CAPACITY - 1)) begin
                w_lru_way = WAY_W'(i);
            end
        end
    end

    // Insert slot selection (against pre-invalidate state) and LRU touch source.
    always_comb begin
        w_do_ins     = we && !flush;
        w_victim_way = (REPL_MODE == 1) ? w_lru_way : r_ptr;
        w_evict      = !w_dup && !w_has_free;
        w_ins_way    = w_dup ? w_dup_way : (w_has_free ? w_free_way : w_victim_way);
        w_touch_en   = w_do_ins || (rd_en && w_hit);
        w_touch_way  = w_do_ins ? w_ins_way : w_hit_way;
    end

    // Next valid vector (flush > insert > invalidate) and its popcount.
    always_comb begin
        w_valid_d = r_valid;
        if (inv_en) begin
            w_valid_d = w_valid_d & ~w_imatch;
        end
        if (w_do_ins) begin
            w_valid_d[w_ins_way] = 1'b1;
        end
        if (flush) begin
            w_valid_d = '0;
        end
        w_occ_d = '0;
        for (int i = 0; i < CAPACITY; i++) begin
            w_occ_d = w_occ_d + (WAY_W + 1)'(w_valid_d[i]);
        end
    end

    // Array, replacement state and eviction report registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid       <= '0;
            r_ptr         <= '0;
            r_evict_valid <= 1'b0;
            r_evict_key   <= '0;
            r_evict_data  <= '0;
            r_occ         <= '0;
            for (int i = 0; i < CAPACITY; i++) begin
                r_keys[i]  <= '0;
                r_lines[i] <= '0;
                r_age[i]   <= WAY_W'(i);
            end
        end else begin
            r_valid       <= w_valid_d;
            r_occ         <= w_occ_d;
            r_evict_valid <= w_do_ins && w_evict;
            if (w_do_ins) begin
                r_keys[w_ins_way]  <= w_key;
                r_lines[w_ins_way] <= data_in;
                if (w_evict) begin
                    r_evict_key  <= r_keys[w_ins_way];
                    r_evict_data <= r_lines[w_ins_way];
                end
            end
            if (REPL_MODE == 0 && w_do_ins && w_evict) begin
                r_ptr <= r_ptr + 1'b1;
            end
            // Touched entry becomes youngest; younger entries age by one, keeping a permutation.
            if (REPL_MODE == 1 && w_touch_en) begin
                for (int i = 0; i < CAPACITY; i++) begin
                    if (WAY_W'(i) == w_touch_way) begin
                        r_age[i] <= '0;
                    end else if (r_age[i] < r_age[w_touch_way]) begin
                        r_age[i] <= r_age[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign victim_hit  = w_hit;
    assign hit_way     = w_hit_way;
    assign data_out    = w_hit ? r_lines[w_hit_way] : '0;
    assign evict_valid = r_evict_valid;
    assign evict_key   = r_evict_key;
    assign evict_data  = r_evict_data;
    assign occupancy   = r_occ;

endmodule

// File: tb/tb_victim_cache_assoc.sv
// Directed bench: one FIFO and one LRU instance (CAPACITY=4) share the same stimulus.
module tb_victim_cache_assoc;

    localparam int unsigned KW = 26;
    localparam int unsigned LW = 64;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          rd_en = 1'b0, we = 1'b0, inv_en = 1'b0, flush = 1'b0;
    logic [KW-1:0] r_key = '0, w_key = '0, inv_key = '0;
    logic [LW-1:0] data_in = '0;

    logic          f_hit, f_ev, l_hit, l_ev;
    logic [1:0]    f_way, l_way;
    logic [2:0]    f_occ, l_occ;
    logic [LW-1:0] f_dout, f_evd, l_dout, l_evd;
    logic [KW-1:0] f_evk, l_evk;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [LW-1:0] DA  = 64'hAAAA_0000_0000_0100;
    localparam logic [LW-1:0] DB  = 64'hBBBB_0000_0000_0101;
    localparam logic [LW-1:0] DC  = 64'hCCCC_0000_0000_0102;
    localparam logic [LW-1:0] D1  = 64'h1111_1111_0000_0001;
    localparam logic [LW-1:0] D2  = 64'h2222_2222_0000_0002;
    localparam logic [LW-1:0] D3  = 64'h3333_3333_0000_0003;
    localparam logic [LW-1:0] D4  = 64'h4444_4444_0000_0004;
    localparam logic [LW-1:0] D5  = 64'h5555_5555_0000_0005;
    localparam logic [LW-1:0] D7A = 64'h7070_7070_0000_0007;
    localparam logic [LW-1:0] D7B = 64'h7171_7171_0000_0007;
    localparam logic [LW-1:0] D30 = 64'h3030_3030_0000_0030;
    localparam logic [LW-1:0] D9  = 64'h9999_9999_0000_0009;
    localparam logic [LW-1:0] DAA = 64'hAAAA_AAAA_0000_00AA;
    localparam logic [LW-1:0] D55 = 64'h5555_0000_0000_0055;
    localparam logic [LW-1:0] D77 = 64'h7777_0000_0000_0077;

    victim_cache_assoc #(
        .TAG_WIDTH(20), .INDEX_WIDTH(6), .LINE_WIDTH(LW), .CAPACITY(4), .REPL_MODE(0)
    ) u_fifo (
        .clk(clk), .rstn(rstn), .rd_en(rd_en), .r_key(r_key),
        .victim_hit(f_hit), .hit_way(f_way), .data_out(f_dout),
        .we(we), .w_key(w_key), .data_in(data_in),
        .inv_en(inv_en), .inv_key(inv_key), .flush(flush),
        .evict_valid(f_ev), .evict_key(f_evk), .evict_data(f_evd), .occupancy(f_occ)
    );

    victim_cache_assoc #(
        .TAG_WIDTH(20), .INDEX_WIDTH(6), .LINE_WIDTH(LW), .CAPACITY(4), .REPL_MODE(1)
    ) u_lru (
        .clk(clk), .rstn(rstn), .rd_en(rd_en), .r_key(r_key),
        .victim_hit(l_hit), .hit_way(l_way), .data_out(l_dout),
        .we(we), .w_key(w_key), .data_in(data_in),
        .inv_en(inv_en), .inv_key(inv_key), .flush(flush),
        .evict_valid(l_ev), .evict_key(l_evk), .evict_data(l_evd), .occupancy(l_occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [KW-1:0] key, input logic [LW-1:0] d);
        we      = 1'b1;
        w_key   = key;
        data_in = d;
        tick();
        we      = 1'b0;
    endtask

    task automatic look(input logic [KW-1:0] key);
        r_key = key;
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic rst_pulse();
        #2 rstn = 1'b0;
        #1;
        chk("rst_f_occ", 64'(f_occ), 64'd0);
        chk("rst_l_occ", 64'(l_occ), 64'd0);
        chk("rst_f_ev", 64'(f_ev), 64'd0);
        chk("rst_f_evk", 64'(f_evk), 64'd0);
        chk("rst_f_evd", f_evd, 64'd0);
        chk("rst_l_evk", 64'(l_evk), 64'd0);
        chk("rst_f_hit", 64'(f_hit), 64'd0);
        chk("rst_l_dout", l_dout, 64'd0);
        #1 rstn = 1'b1;
    endtask

    initial begin
        // Reset values
        #3;
        chk("init_f_occ", 64'(f_occ), 64'd0);
        chk("init_l_ev", 64'(l_ev), 64'd0);
        chk("init_f_evd", f_evd, 64'd0);
        chk("init_f_hit", 64'(f_hit), 64'd0);
        #9 rstn = 1'b1;

        // Basic fill and lookup
        ins(26'h100, DA);
        ins(26'h101, DB);
        ins(26'h102, DC);
        chk("fill_f_occ", 64'(f_occ), 64'd3);
        chk("fill_l_occ", 64'(l_occ), 64'd3);
        look(26'h101);
        chk("lk101_f_hit", 64'(f_hit), 64'd1);
        chk("lk101_f_way", 64'(f_way), 64'd1);
        chk("lk101_f_dout", f_dout, DB);
        chk("lk101_l_dout", l_dout, DB);
        look(26'h200);
        chk("lk200_f_hit", 64'(f_hit), 64'd0);
        chk("lk200_f_dout", f_dout, 64'd0);
        chk("lk200_f_way", 64'(f_way), 64'd0);
        chk("lk200_l_hit", 64'(l_hit), 64'd0);

        // Replacement: keys 1..4, read-touch key 1, then key 5
        rst_pulse();
        ins(26'd1, D1);
        ins(26'd2, D2);
        ins(26'd3, D3);
        ins(26'd4, D4);
        chk("full_f_ev", 64'(f_ev), 64'd0);
        rd_en = 1'b1;
        look(26'd1);
        chk("touch_l_hit", 64'(l_hit), 64'd1);
        chk("touch_l_way", 64'(l_way), 64'd0);
        tick();
        rd_en = 1'b0;
        ins(26'd5, D5);
        chk("k5_f_ev", 64'(f_ev), 64'd1);
        chk("k5_f_evk", 64'(f_evk), 64'd1);
        chk("k5_f_evd", f_evd, D1);
        chk("k5_f_occ", 64'(f_occ), 64'd4);
        chk("k5_l_ev", 64'(l_ev), 64'd1);
        chk("k5_l_evk", 64'(l_evk), 64'd2);
        chk("k5_l_evd", l_evd, D2);
        chk("k5_l_occ", 64'(l_occ), 64'd4);
        look(26'd1);
        chk("k1_f_hit", 64'(f_hit), 64'd0);
        chk("k1_l_hit", 64'(l_hit), 64'd1);
        look(26'd5);
        chk("k5_f_way", 64'(f_way), 64'd0);
        chk("k5_l_way", 64'(l_way), 64'd1);
        tick();
        chk("pulse_f_ev", 64'(f_ev), 64'd0);
        chk("pulse_l_ev", 64'(l_ev), 64'd0);
        chk("hold_l_evk", 64'(l_evk), 64'd2);

        // Duplicate insert
        ins(26'd7, D7A);
        chk("k7a_f_evk", 64'(f_evk), 64'd2);
        chk("k7a_l_evk", 64'(l_evk), 64'd3);
        ins(26'd7, D7B);
        chk("dup_f_ev", 64'(f_ev), 64'd0);
        chk("dup_l_ev", 64'(l_ev), 64'd0);
        chk("dup_f_occ", 64'(f_occ), 64'd4);
        chk("dup_l_occ", 64'(l_occ), 64'd4);
        look(26'd7);
        chk("dup_f_dout", f_dout, D7B);
        chk("dup_l_dout", l_dout, D7B);
        chk("dup_f_way", 64'(f_way), 64'd1);
        chk("dup_l_way", 64'(l_way), 64'd2);

        // Invalidate, slot reuse, same-cycle insert+invalidate
        inv_en  = 1'b1;
        inv_key = 26'd7;
        tick();
        inv_en  = 1'b0;
        look(26'd7);
        chk("inv_f_hit", 64'(f_hit), 64'd0);
        chk("inv_l_hit", 64'(l_hit), 64'd0);
        chk("inv_f_occ", 64'(f_occ), 64'd3);
        chk("inv_l_occ", 64'(l_occ), 64'd3);
        chk("inv_f_ev", 64'(f_ev), 64'd0);
        ins(26'h30, D30);
        chk("reuse_f_ev", 64'(f_ev), 64'd0);
        chk("reuse_l_ev", 64'(l_ev), 64'd0);
        chk("reuse_f_occ", 64'(f_occ), 64'd4);
        look(26'h30);
        chk("reuse_f_way", 64'(f_way), 64'd1);
        chk("reuse_l_way", 64'(l_way), 64'd2);
        inv_en  = 1'b1;
        inv_key = 26'd9;
        ins(26'd9, D9);
        inv_en  = 1'b0;
        look(26'd9);
        chk("wi9_f_hit", 64'(f_hit), 64'd1);
        chk("wi9_l_hit", 64'(l_hit), 64'd1);
        chk("wi9_f_dout", f_dout, D9);
        chk("wi9_f_way", 64'(f_way), 64'd2);
        chk("wi9_l_way", 64'(l_way), 64'd3);
        chk("wi9_f_evk", 64'(f_evk), 64'd3);
        chk("wi9_l_evk", 64'(l_evk), 64'd4);
        chk("wi9_l_occ", 64'(l_occ), 64'd4);

        // Flush together with insert
        flush = 1'b1;
        ins(26'hAA, DAA);
        flush = 1'b0;
        chk("fl_f_occ", 64'(f_occ), 64'd0);
        chk("fl_l_occ", 64'(l_occ), 64'd0);
        chk("fl_f_ev", 64'(f_ev), 64'd0);
        chk("fl_l_ev", 64'(l_ev), 64'd0);
        look(26'd9);
        chk("fl_f_hit9", 64'(f_hit), 64'd0);
        look(26'hAA);
        chk("fl_l_hitAA", 64'(l_hit), 64'd0);
        ins(26'h55, D55);
        chk("p55_f_occ", 64'(f_occ), 64'd1);
        chk("p55_f_evk", 64'(f_evk), 64'd3);
        r_key = 26'h55;

        // Async reset mid-stream, then state behaves as freshly reset
        rst_pulse();
        ins(26'h77, D77);
        look(26'h77);
        chk("post_f_way", 64'(f_way), 64'd0);
        chk("post_l_way", 64'(l_way), 64'd0);
        chk("post_l_dout", l_dout, D77);
        chk("post_l_occ", 64'(l_occ), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/victim_cache_assoc.md
Name: victim_cache_assoc

Overview:
- Parametrised, fully-associative victim cache that succeeds the fixed 16-entry instruction victim buffer.
- Holds lines displaced from an L1 cache (I or D). Lookup is combinational, in the same cycle as the L1 tag compare. Insert, invalidate and flush are synchronous.
- New relative to the previous generation:
  - selectable replacement policy (FIFO or true LRU);
  - duplicate-free insert;
  - single-key invalidate (used for swap-back on hit) and full flush;
  - registered eviction report;
  - occupancy output.

Parameters:
TAG_WIDTH, 20, tag bits of line key
INDEX_WIDTH, 6, set-index bits of line key; KEY_W = TAG_WIDTH+INDEX_WIDTH
LINE_WIDTH, 512, data bits per line
CAPACITY, 16, number of entries; power of two, 2..64; WAY_W = log2(CAPACITY)
REPL_MODE, 0, 0 = FIFO pointer, 1 = true LRU (age counters)

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
rd_en  in  1  lookup valid; qualifies the LRU touch
r_key  in  KEY_W  lookup key {tag,index}
victim_hit  out  1  combinational: some valid entry matches r_key (independent of rd_en)
hit_way  out  WAY_W  lowest-index matching entry; 0 when no hit
data_out  out  LINE_WIDTH  data of hit_way; all-zero when no hit
we  in  1  insert request; every cycle we=1 performs one insert (level, not edge)
w_key  in  KEY_W  key to insert
data_in  in  LINE_WIDTH  line to insert
inv_en  in  1  invalidate request
inv_key  in  KEY_W  key to invalidate
flush  in  1  invalidate all entries
evict_valid  out  1  registered; 1-cycle pulse, a valid line was overwritten by an insert
evict_key  out  KEY_W  registered key of displaced line
evict_data  out  LINE_WIDTH  registered data of displaced line
occupancy  out  WAY_W+1  number of valid entries

Behaviour:
- Reset (rstn=0, async):
  - all valid bits 0; data and keys cleared to 0;
  - FIFO pointer = 0; LRU age[i] = i;
  - evict_valid = 0, evict_key = 0, evict_data = 0, occupancy = 0.
- Lookup: purely combinational on current state. A write in the same cycle is not visible until the next cycle.
- Insert (we=1) slot selection, in priority order:
  - (a) an existing valid entry whose key equals w_key: overwrite its data in place; no eviction; FIFO pointer unchanged;
  - (b) else the lowest-index invalid entry;
  - (c) else the replacement victim:
    - FIFO: entry at pointer, then pointer increments modulo CAPACITY;
    - LRU: the entry with age = CAPACITY-1.
  - Only case (c) sets evict_valid=1 next cycle, with the old key/data.
- LRU update (REPL_MODE=1):
  - touched entry age ← 0; every entry with age < old age of touched ← age+1.
  - Ages always form a permutation of 0..CAPACITY-1.
  - Touch sources: the insert slot. If there is no insert that cycle, rd_en && victim_hit touches hit_way.
  - With an insert, the insert touch wins and the read touch is dropped.
- FIFO mode ignores rd_en for state.
- Invalidate: inv_en clears the valid bit of every entry matching inv_key. Ages and pointer are unchanged. A matching entry is not counted as an eviction.
- Same-cycle priority: flush > insert > invalidate.
  - flush with we: all entries invalid; the insert is dropped; evict_valid=0.
  - we and inv_en with equal keys: the insert wins and the entry ends valid with data_in.
  - we and inv_en with different keys: both take effect. The insert slot is selected against pre-invalidate state.
- Flush: all valid bits 0 next cycle. Ages and pointer are not reset. occupancy = 0 next cycle.
- occupancy: registered; equals the popcount of valid bits after the edge's updates.
- evict_valid is 0 in any cycle following an edge with no case-(c) insert. evict_key/evict_data hold their last value.
- Duplicate keys never exist in the array. hit_way priority encoder is still lowest-index for safety.

Test Plan:
- Reset, then 3 inserts keys 0x100/0x101/0x102 with data A/B/C → entries 0..2 valid, occupancy=3; r_key=0x101 gives victim_hit=1, hit_way=1, data_out=B; r_key=0x200 gives hit=0, data_out=0.
- FIFO, CAPACITY=4: insert keys 1..5 → 5th insert lands in entry 0; next cycle evict_valid=1, evict_key=1, evict_data=data of key 1; occupancy stays 4.
- LRU, CAPACITY=4: insert keys 1..4, rd_en hit on key 1, insert key 5 → key 2 is evicted, key 1 still hits.
- Duplicate insert: insert key 7 with D0, then key 7 with D1 → occupancy unchanged; data_out=D1; evict_valid=0.
- Invalidate: inv_en key 0x101 → hit=0 next cycle, occupancy −1; the next insert reuses that slot with no eviction. Same-cycle we=inv_en=1 on key 9 → key 9 valid.
- Flush asserted together with we, then async rstn pulse mid-stream → all invalid, occupancy=0, evict_valid=0; state after rstn matches the reset values.
